// File: rtl/gpio_bank_pkg.sv
// Shared register-map constants and helpers for the parametrised GPIO bank.
// Register offsets are multiples of the per-register word count W.
package gpio_bank_pkg;

  localparam int unsigned REG_DIR     = 0;
  localparam int unsigned REG_OUT     = 1;
  localparam int unsigned REG_IN      = 2;
  localparam int unsigned REG_RISE_EN = 3;
  localparam int unsigned REG_FALL_EN = 4;
  localparam int unsigned REG_STATUS  = 5;
  localparam int unsigned REG_OUT_SET = 6;
  localparam int unsigned REG_OUT_CLR = 7;
  localparam int unsigned NUM_REGS    = 8;

  localparam logic RESET_LEVEL = 1'b0;
  localparam int   RESET_COUNT = 0;

  function automatic int unsigned calc_words(input int unsigned ports,
                                             input int unsigned port_width,
                                             input int unsigned data_width);
    return (ports * port_width) / data_width;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser and edge detector for one bus-word slice of pins.
// Edges are masked until the synchroniser has flushed its reset contents.
module gpio_sync_edge
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int ARM_COUNT = SYNC_STAGES + 1;
  localparam int CW        = $clog2(ARM_COUNT + 1);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] s_d;
  logic [CW-1:0]    arm_cnt;
  logic             armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        chain[i] <= {WIDTH{RESET_LEVEL}};
      end
      s_d <= {WIDTH{RESET_LEVEL}};
    end else begin
      chain[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      s_d <= chain[SYNC_STAGES-1];
    end
  end

  // Saturating counter: pins already high at reset must not look like rising edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_cnt <= CW'(RESET_COUNT);
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign armed    = (arm_cnt == CW'(ARM_COUNT));
  assign sync_out = chain[SYNC_STAGES-1];
  assign rise     = armed ? (sync_out & ~s_d) : '0;
  assign fall     = armed ? (~sync_out & s_d) : '0;

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank on the gpmc_sync bus: direction/output registers,
// atomic set/clear, synchronised inputs and W1C edge interrupts.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int PORTS       = 4,
  parameter int PORT_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs,
  input  logic                   we,
  input  logic                   oe,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [DATA_WIDTH-1:0]  data_out,
  output logic [DATA_WIDTH-1:0]  data_in,
  input  logic [PORTS*PORT_WIDTH-1:0] pin_in,
  output logic [PORTS*PORT_WIDTH-1:0] pin_out,
  output logic [PORTS*PORT_WIDTH-1:0] pin_oe,
  output logic                   irq
);

  localparam int          N  = PORTS * PORT_WIDTH;
  localparam int          DW = DATA_WIDTH;
  localparam int unsigned W  = calc_words(PORTS, PORT_WIDTH, DATA_WIDTH);

  generate
    if ((N % DW) != 0) begin : g_bad_width
      $error("gpio_bank: pin count must be a multiple of DATA_WIDTH");
    end
    if ((NUM_REGS * W) > (2 ** ADDR_WIDTH)) begin : g_bad_addr
      $error("gpio_bank: ADDR_WIDTH too small for register map");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("gpio_bank: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic          wc, wc_d, wr_pulse, rc;
  logic [N-1:0]  dir_q, out_q, rise_en, fall_en, status;
  logic [N-1:0]  s, rise, fall, edge_set, status_clr;
  int unsigned   addr_u, reg_idx, word_idx;
  logic          mapped;
  logic [DW-1:0] rd_word;

  assign wc       = !cs && !we && oe;
  assign rc       = !cs && we && !oe;
  assign wr_pulse = wc && !wc_d;

  assign addr_u   = 32'(address);
  assign reg_idx  = addr_u / W;
  assign word_idx = addr_u % W;
  assign mapped   = (addr_u < (NUM_REGS * W));

  for (genvar k = 0; k < int'(W); k++) begin : g_slice
    gpio_sync_edge #(
      .WIDTH      (DW),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk     (clk),
      .rst     (rst),
      .pin_in  (pin_in[k*DW +: DW]),
      .sync_out(s[k*DW +: DW]),
      .rise    (rise[k*DW +: DW]),
      .fall    (fall[k*DW +: DW])
    );
  end

  assign edge_set = (rise & rise_en) | (fall & fall_en);

  always_comb begin
    status_clr = '0;
    if (wr_pulse && mapped && (reg_idx == REG_STATUS)) begin
      status_clr[word_idx*DW +: DW] = data_out;
    end
  end

  // Writes act once per rising write condition; a new edge beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      wc_d    <= RESET_LEVEL;
      dir_q   <= {N{RESET_LEVEL}};
      out_q   <= {N{RESET_LEVEL}};
      rise_en <= {N{RESET_LEVEL}};
      fall_en <= {N{RESET_LEVEL}};
      status  <= {N{RESET_LEVEL}};
    end else begin
      wc_d   <= wc;
      status <= (status & ~status_clr) | edge_set;
      if (wr_pulse && mapped) begin
        case (reg_idx)
          REG_DIR:     dir_q[word_idx*DW +: DW]   <= data_out;
          REG_OUT:     out_q[word_idx*DW +: DW]   <= data_out;
          REG_RISE_EN: rise_en[word_idx*DW +: DW] <= data_out;
          REG_FALL_EN: fall_en[word_idx*DW +: DW] <= data_out;
          REG_OUT_SET: out_q[word_idx*DW +: DW]   <= out_q[word_idx*DW +: DW] | data_out;
          REG_OUT_CLR: out_q[word_idx*DW +: DW]   <= out_q[word_idx*DW +: DW] & ~data_out;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (mapped) begin
      case (reg_idx)
        REG_DIR:     rd_word = dir_q[word_idx*DW +: DW];
        REG_OUT:     rd_word = out_q[word_idx*DW +: DW];
        REG_IN:      rd_word = s[word_idx*DW +: DW];
        REG_RISE_EN: rd_word = rise_en[word_idx*DW +: DW];
        REG_FALL_EN: rd_word = fall_en[word_idx*DW +: DW];
        REG_STATUS:  rd_word = status[word_idx*DW +: DW];
        default:     rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_in <= {DW{RESET_LEVEL}};
      irq     <= RESET_LEVEL;
    end else begin
      data_in <= rc ? rd_word : '0;
      irq     <= |status;
    end
  end

  assign pin_oe  = dir_q;
  assign pin_out = out_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank: a register-map level model is
// compared every cycle, plus literal expectations at key points.
module tb_gpio_bank;

  localparam int S  = 2;
  localparam int W  = 2;
  localparam int DW = 16;

  logic        clk;
  logic        rst;
  logic        cs, we, oe;
  logic [3:0]  address;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic [31:0] pin_in, pin_out, pin_oe;
  logic        irq;

  logic        b_cs, b_we, b_oe;
  logic [3:0]  b_addr;
  logic [31:0] b_wdata, b_rdata, b_pin_in, b_pin_out, b_pin_oe;
  logic        b_irq;

  int vectors;
  int miscompares;
  logic cmp_en;

  gpio_bank dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .oe(oe),
    .address(address), .data_out(data_out), .data_in(data_in),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  gpio_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut_w1 (
    .clk(clk), .rst(rst), .cs(b_cs), .we(b_we), .oe(b_oe),
    .address(b_addr), .data_out(b_wdata), .data_in(b_rdata),
    .pin_in(b_pin_in), .pin_out(b_pin_out), .pin_oe(b_pin_oe), .irq(b_irq)
  );

  always #5 clk = ~clk;

  // Register-map model: pin history as a delay line, registers as plain words.
  logic [31:0] m_dir, m_out, m_rise, m_fall, m_status;
  logic        m_irq, m_wc_prev;
  logic [15:0] m_rdata;
  logic [31:0] pipe [0:S];
  int          m_edges;

  function automatic logic [15:0] model_word(input int idx);
    logic [31:0] v;
    int r, k;
    r = idx / W;
    k = idx % W;
    case (r)
      0: v = m_dir;
      1: v = m_out;
      2: v = pipe[S-1];
      3: v = m_rise;
      4: v = m_fall;
      5: v = m_status;
      default: v = 32'h0;
    endcase
    v = v >> (k * DW);
    return v[15:0];
  endfunction

  task automatic model_step();
    logic        wc_now, rc_now, pulse;
    logic [31:0] s_old, sd_old, set_m, clr_m, wmask, lane;
    int          r, k;
    if (rst) begin
      m_dir = 0; m_out = 0; m_rise = 0; m_fall = 0; m_status = 0;
      m_irq = 0; m_rdata = 0; m_wc_prev = 0; m_edges = 0;
      for (int i = 0; i <= S; i++) pipe[i] = 0;
    end else begin
      m_edges++;
      wc_now = !cs && !we && oe;
      rc_now = !cs && we && !oe;
      pulse = wc_now && !m_wc_prev;
      m_wc_prev = wc_now;
      s_old = pipe[S-1];
      sd_old = pipe[S];
      set_m = (m_edges >= S + 2) ? ((s_old & ~sd_old & m_rise) | (~s_old & sd_old & m_fall)) : 32'h0;
      m_rdata = rc_now ? model_word(int'(address)) : 16'h0;
      m_irq = |m_status;
      clr_m = 0;
      if (pulse) begin
        r = int'(address) / W;
        k = int'(address) % W;
        wmask = {16'h0, data_out} << (k * DW);
        lane = 32'h0000FFFF << (k * DW);
        case (r)
          0: m_dir  = (m_dir  & ~lane) | wmask;
          1: m_out  = (m_out  & ~lane) | wmask;
          3: m_rise = (m_rise & ~lane) | wmask;
          4: m_fall = (m_fall & ~lane) | wmask;
          5: clr_m  = wmask;
          6: m_out  = m_out | wmask;
          7: m_out  = m_out & ~wmask;
          default: ;
        endcase
      end
      m_status = (m_status & ~clr_m) | set_m;
      for (int i = S; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = pin_in;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("model_pin_oe", pin_oe, m_dir);
      check_output("model_pin_out", pin_out, m_out);
      check_output("model_irq", {31'h0, irq}, {31'h0, m_irq});
      check_output("model_data_in", {16'h0, data_in}, {16'h0, m_rdata});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    cs = 1'b1; we = 1'b1; oe = 1'b1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
    address = a; data_out = d;
    cs = 1'b0; we = 1'b0; oe = 1'b1;
    tick(1);
    bus_idle();
    tick(1);
  endtask

  task automatic read_reg(input logic [3:0] a, input logic [15:0] exp, input string name);
    address = a;
    cs = 1'b0; we = 1'b1; oe = 1'b0;
    tick(1);
    check_output(name, {16'h0, data_in}, {16'h0, exp});
    bus_idle();
    tick(1);
  endtask

  task automatic b_write(input logic [3:0] a, input logic [31:0] d);
    b_addr = a; b_wdata = d;
    b_cs = 1'b0; b_we = 1'b0; b_oe = 1'b1;
    tick(1);
    b_cs = 1'b1; b_we = 1'b1;
    tick(1);
  endtask

  task automatic b_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    b_addr = a;
    b_cs = 1'b0; b_we = 1'b1; b_oe = 1'b0;
    tick(1);
    check_output(name, b_rdata, exp);
    b_cs = 1'b1; b_oe = 1'b1;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0; cmp_en = 1'b0;
    clk = 1'b0; rst = 1'b1;
    bus_idle();
    address = 0; data_out = 0;
    pin_in = 32'hFFFF_FFFF;
    b_cs = 1'b1; b_we = 1'b1; b_oe = 1'b1; b_addr = 0; b_wdata = 0; b_pin_in = 0;

    tick(3);
    cmp_en = 1'b1;
    check_output("reset_pin_oe", pin_oe, 32'h0);
    check_output("reset_pin_out", pin_out, 32'h0);
    check_output("reset_irq", {31'h0, irq}, 32'h0);
    check_output("reset_data_in", {16'h0, data_in}, 32'h0);
    check_output("reset_w1_irq", {31'h0, b_irq}, 32'h0);

    // Pins high through reset, rising edges enabled right away: must stay quiet.
    rst = 1'b0;
    write_reg(4'd6, 16'hFFFF);
    write_reg(4'd7, 16'hFFFF);
    tick(6);
    check_output("arm_irq", {31'h0, irq}, 32'h0);
    read_reg(4'd10, 16'h0000, "arm_status0");
    read_reg(4'd11, 16'h0000, "arm_status1");
    pin_in = 32'h0;
    tick(5);
    write_reg(4'd6, 16'h0001);
    write_reg(4'd7, 16'h0000);

    write_reg(4'd0, 16'h00FF);
    write_reg(4'd2, 16'h0055);
    check_output("dir_pin_oe", pin_oe, 32'h0000_00FF);
    check_output("out_pin_out", pin_out, 32'h0000_0055);
    read_reg(4'd0, 16'h00FF, "read_dir0");

    write_reg(4'd3, 16'hF0F0);
    write_reg(4'd13, 16'h000F);
    write_reg(4'd15, 16'hF000);
    check_output("setclr_pin_out", pin_out, 32'h00FF_0055);
    read_reg(4'd13, 16'h0000, "read_out_set");
    read_reg(4'd15, 16'h0000, "read_out_clr");

    pin_in = 32'h0000_0001;
    tick(3);
    check_output("rise_irq_t3", {31'h0, irq}, 32'h0);
    tick(1);
    check_output("rise_irq_t4", {31'h0, irq}, 32'h1);
    read_reg(4'd10, 16'h0001, "read_status0");
    write_reg(4'd10, 16'h0001);
    check_output("w1c_irq", {31'h0, irq}, 32'h0);
    read_reg(4'd10, 16'h0000, "status0_cleared");

    pin_in = 32'h8000_0001;
    tick(5);
    write_reg(4'd9, 16'h8000);
    pin_in = 32'h0000_0001;
    tick(5);
    check_output("fall_irq", {31'h0, irq}, 32'h1);
    pin_in = 32'h8000_0001;
    tick(5);
    pin_in = 32'h0000_0001;
    tick(2);
    write_reg(4'd11, 16'h8000);
    check_output("setwins_irq", {31'h0, irq}, 32'h1);
    read_reg(4'd11, 16'h8000, "setwins_status1");
    write_reg(4'd11, 16'h8000);
    check_output("status1_clear_irq", {31'h0, irq}, 32'h0);

    // Held write condition with changing data: only the first cycle's data lands.
    address = 4'd12; data_out = 16'h0100;
    cs = 1'b0; we = 1'b0; oe = 1'b1;
    tick(1);
    data_out = 16'h0200;
    tick(4);
    bus_idle();
    tick(1);
    check_output("held_out_set", pin_out, 32'h00FF_0155);

    b_write(4'd0, 32'hDEAD_BEEF);
    check_output("w1_pin_oe", b_pin_oe, 32'hDEAD_BEEF);
    b_write(4'd12, 32'hFFFF_FFFF);
    check_output("w1_unmapped_write", b_pin_out, 32'h0);
    b_read(4'd9, 32'h0, "w1_unmapped_read");
    b_read(4'd0, 32'hDEAD_BEEF, "w1_read_dir");

    address = 4'd0;
    cs = 1'b0; we = 1'b1; oe = 1'b0;
    rst = 1'b1;
    tick(1);
    check_output("rst_read_data_in", {16'h0, data_in}, 32'h0);
    check_output("rst_pin_oe", pin_oe, 32'h0);
    bus_idle();
    tick(1);
    rst = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised GPIO bank behind the gpmc_sync bus controller. Generalises the fixed 4×8-pin port block to PORTS×PORT_WIDTH pins.
- Adds input synchronisers, atomic set/clear output registers, and per-pin rise/fall edge interrupts with write-1-to-clear status.
- Drives pin_oe/pin_out and samples pin_in; the top level instantiates the tristate buffers.

Parameters:
- PORTS, 4: number of pmod-style ports.
- PORT_WIDTH, 8: pins per port; N = PORTS*PORT_WIDTH.
- DATA_WIDTH, 16: bus word width. N must be a multiple of DATA_WIDTH; W = N/DATA_WIDTH words per register.
- ADDR_WIDTH, 4: word address width. Requires 8*W <= 2^ADDR_WIDTH.
- SYNC_STAGES, 2: input synchroniser depth, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  chip select from gpmc_sync, active low.
- we  in  1  write enable from gpmc_sync, active low.
- oe  in  1  output enable from gpmc_sync, active low.
- address  in  ADDR_WIDTH  word address.
- data_out  in  DATA_WIDTH  write data (bus to block).
- data_in  out  DATA_WIDTH  read data (block to bus).
- pin_in  in  N  raw pad inputs, asynchronous.
- pin_out  out  N  pad output values.
- pin_oe  out  N  pad output enables; 1 = drive.
- irq  out  1  level interrupt to host.

Behaviour:
- Register map, word index k in 0..W-1; word k holds pins [k*DW +: DW]:
  - DIR at k (RW)
  - OUT at W+k (RW)
  - IN at 2W+k (RO)
  - RISE_EN at 3W+k (RW)
  - FALL_EN at 4W+k (RW)
  - STATUS at 5W+k (RW1C)
  - OUT_SET at 6W+k (WO)
  - OUT_CLR at 7W+k (WO)
- Unmapped addresses: writes ignored, reads return 0. Write-only registers read 0.
- Write condition wc = !cs & !we & oe. The register is updated once, on the cycle after wc rises (wr_pulse = wc & !wc_d, taking the address and data_out present on that cycle). Holding wc for multiple cycles does not repeat the write.
- Read condition rc = !cs & we & !oe. data_in is registered: data_in <= selected word one cycle after rc is sampled, otherwise 0.
- pin_oe = DIR; pin_out = OUT; both are registered outputs.
- OUT_SET: OUT |= word. OUT_CLR: OUT &= ~word. The change is visible on pin_out the cycle after wr_pulse.
- Input path: pin_in passes through SYNC_STAGES flops to give s. IN reads s regardless of DIR. One further flop gives s_d.
- Edge detection: rise = s & ~s_d; fall = ~s & s_d.
  - STATUS[i] sets when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - A STATUS write clears the bits written as 1.
  - A set and a clear of the same bit in the same cycle: set wins.
- irq = |(STATUS), registered; it lags a STATUS change by 1 cycle.
- Edge latency: a pin_in change produces STATUS set SYNC_STAGES+1 cycles later and irq one cycle after that.
- Post-reset arming: a counter suppresses edge detection for SYNC_STAGES+1 cycles after rst deasserts, so pins already high at reset do not raise spurious interrupts.
- Reset values (all zero):
  - DIR, OUT, RISE_EN, FALL_EN, STATUS = 0
  - sync flops, s_d, wc_d = 0
  - data_in = 0, irq = 0, pin_oe = 0 (all inputs), pin_out = 0
  - arming counter = 0 (disarmed)
- Reset asserted mid-transaction aborts it; the write is not retried.

Decomposition:
- Shared package gpio_bank_pkg holds:
  - register-offset constants as multiples of W: REG_DIR=0 … REG_OUT_CLR=7
  - the function computing W
  - the RESET_* zero constants
- Sub-module gpio_sync_edge, one instance per DATA_WIDTH slice:
  - contains the synchroniser, s_d, rise/fall detection and the arming gate
  - parameters WIDTH and SYNC_STAGES

Test Plan (defaults: N=32, W=2):
- Reset with pin_in=0xFFFF_FFFF, RISE_EN all 1 (written after reset) → STATUS stays 0 and irq stays 0.
- Write DIR word0=0x00FF, OUT word0=0x0055 → pin_oe[15:0]=0x00FF, pin_out[15:0]=0x0055. Read of addr 0 returns 0x00FF one cycle after rc.
- OUT word1=0xF0F0, then OUT_SET word1(addr 13)=0x000F, then OUT_CLR word1(addr 15)=0xF000 → pin_out[31:16]=0x00FF. Reads of addr 13 and 15 return 0.
- RISE_EN word0=0x0001; drive pin_in[0] 0→1 at cycle t → STATUS[0]=1 at t+3, irq=1 at t+4. Read STATUS word0=0x0001. Write 0x0001 to addr 10 → irq=0 next cycle.
- FALL_EN word1=0x8000; pin_in[31] 1→0 on the same cycle the edge would coincide with a W1C of bit 31 → bit remains 1 (set wins).
- wc held for 5 cycles on OUT_SET → single update. Read of unmapped address (with W=1 config) returns 0. rst asserted during a read → data_in=0 next cycle.
